// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single full-subtractor cell. Pulses done when the result is ready.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t            state_reg;
  logic [WIDTH-1:0]  a_sh_reg;
  logic [WIDTH-1:0]  b_sh_reg;
  logic [WIDTH-1:0]  res_sh_reg;
  logic              borrow_reg;
  logic [CW-1:0]     cnt_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [WIDTH-1:0]  diff_reg;
  logic              bout_reg;

  logic              x_bit;
  logic              y_bit;
  logic              d_bit;
  logic              borrow_next;
  logic [WIDTH-1:0]  res_next;

  // The single full-subtractor cell operating on the current LSBs.
  always_comb begin
    x_bit       = a_sh_reg[0];
    y_bit       = b_sh_reg[0];
    d_bit       = x_bit ^ y_bit ^ borrow_reg;
    borrow_next = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & borrow_reg);
    res_next    = {d_bit, res_sh_reg[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_sh_reg <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      diff_reg   <= '0;
      bout_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (start) begin
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            borrow_reg <= bin;
            res_sh_reg <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= SHIFT;
          end else begin
            state_reg  <= IDLE;
          end
        end
        SHIFT: begin
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          res_sh_reg <= res_next;
          borrow_reg <= borrow_next;
          cnt_reg    <= cnt_reg + 1'b1;
          // diff/bout are only published here, so partial results never leak.
          if (cnt_reg == LAST) begin
            diff_reg  <= res_next;
            bout_reg  <= borrow_next;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign diff = diff_reg;
  assign bout = bout_reg;

endmodule
